// File: rtl/sequential_cordic_processor_top.sv
// -----------------------------------------------------------------------------
// sequential_cordic_processor_top
//
// Computes the N_DIM-1 hyperspherical angles of a signed N_DIM-element vector
// by running one shared vectoring CORDIC core N_DIM-1 times. The core's output
// magnitude becomes the x operand of the next step:
//   r1 = w1;  theta_k = atan2(w(k+1), r_k);  r(k+1) = |(r_k, w(k+1))|
//
// Angle format: signed binary angle, LSB = pi/2^(ANGLE_WIDTH-1)
// (+pi/2 = 16384, pi/4 = 8192, +/-pi = -32768 at 16 bits).
//
// Ports
//   clk        : clock, rising edge
//   nreset     : asynchronous active-low reset
//   start      : one-cycle request, honoured only in IDLE or DONE
//   w_in_flat  : input vector, w1 in the lowest DATA_WIDTH slice
//   theta_out  : angles, theta1 in the lowest ANGLE_WIDTH slice
//   done       : high from result completion until the next accepted start
//   fsm_state  : current controller state (debug visibility)
//
// Core handshake: enable is a one-cycle pulse that loads (x_in, y_in); exactly
// CORDIC_STAGES+2 cycles later valid pulses for one cycle, and angle_out /
// mag_out hold their values until the next enable. No back-pressure exists:
// the controller waits for valid before issuing again.
// -----------------------------------------------------------------------------
module cordic_vectoring_top1 #(
   parameter int DATA_WIDTH    = 16,
   parameter int ANGLE_WIDTH   = 16,
   parameter int CORDIC_WIDTH  = 22,
   parameter int CORDIC_STAGES = 16
) (
   input  logic                          clk,
   input  logic                          nreset,
   input  logic                          enable,
   input  logic signed [DATA_WIDTH-1:0]  x_in,
   input  logic signed [DATA_WIDTH-1:0]  y_in,
   output logic signed [ANGLE_WIDTH-1:0] angle_out,
   output logic signed [DATA_WIDTH-1:0]  mag_out,
   output logic                          valid
);
   // Two bits of headroom cover the sqrt(2) * 1.647 magnitude growth; the
   // remaining low bits are guard bits that keep truncation error small.
   localparam int GUARD = CORDIC_WIDTH - DATA_WIDTH - 2;
   localparam int IW    = (CORDIC_STAGES > 1) ? $clog2(CORDIC_STAGES) : 1;
   localparam int PW    = CORDIC_WIDTH + 17;
   // round(0.607253 * 2^15)
   localparam logic signed [16:0] GAIN = 17'sd19898;
   localparam logic signed [ANGLE_WIDTH-1:0] Z_PI = {1'b1, {(ANGLE_WIDTH-1){1'b0}}};
   localparam logic signed [PW-1:0] SAT_HI =
      $signed({{(PW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}});
   localparam logic signed [PW-1:0] SAT_LO =
      $signed({{(PW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}});

   // atan(2^-i) in binary-angle units (16-bit angle scale).
   function automatic logic signed [ANGLE_WIDTH-1:0] atan_rom(input int i);
      case (i)
         0:       atan_rom = ANGLE_WIDTH'(8192);
         1:       atan_rom = ANGLE_WIDTH'(4836);
         2:       atan_rom = ANGLE_WIDTH'(2555);
         3:       atan_rom = ANGLE_WIDTH'(1297);
         4:       atan_rom = ANGLE_WIDTH'(651);
         5:       atan_rom = ANGLE_WIDTH'(326);
         6:       atan_rom = ANGLE_WIDTH'(163);
         7:       atan_rom = ANGLE_WIDTH'(81);
         8:       atan_rom = ANGLE_WIDTH'(41);
         9:       atan_rom = ANGLE_WIDTH'(20);
         10:      atan_rom = ANGLE_WIDTH'(10);
         11:      atan_rom = ANGLE_WIDTH'(5);
         12:      atan_rom = ANGLE_WIDTH'(3);
         13:      atan_rom = ANGLE_WIDTH'(1);
         14:      atan_rom = ANGLE_WIDTH'(1);
         default: atan_rom = '0;
      endcase
   endfunction

   logic signed [CORDIC_WIDTH-1:0] x_r, y_r, x_ext, y_ext;
   logic signed [CORDIC_WIDTH-1:0] x_nx, y_nx, x_sh, y_sh;
   logic signed [ANGLE_WIDTH-1:0]  z_r, z_nx, atan_c;
   logic signed [PW-1:0]           prod, scaled;
   logic signed [DATA_WIDTH-1:0]   mag_sat;
   logic [IW-1:0]                  iter;
   logic                           busy, gain_pend, y_zero, x_neg;

   assign x_ext = CORDIC_WIDTH'(x_in) <<< GUARD;
   assign y_ext = CORDIC_WIDTH'(y_in) <<< GUARD;

   // One micro-rotation: rotate toward y = 0, tracking the angle in z.
   always_comb begin
      x_sh   = x_r >>> iter;
      y_sh   = y_r >>> iter;
      atan_c = atan_rom(int'(iter));
      x_nx   = x_r;
      y_nx   = y_r;
      z_nx   = z_r;
      if (!y_r[CORDIC_WIDTH-1]) begin
         x_nx = x_r + y_sh;
         y_nx = y_r - x_sh;
         z_nx = z_r + atan_c;
      end else begin
         x_nx = x_r - y_sh;
         y_nx = y_r + x_sh;
         z_nx = z_r - atan_c;
      end
   end

   // Gain compensation folds the guard-bit removal into the same shift.
   always_comb begin
      prod   = PW'(x_r) * PW'(GAIN);
      scaled = prod >>> (15 + GUARD);
      if (scaled > SAT_HI)      mag_sat = SAT_HI[DATA_WIDTH-1:0];
      else if (scaled < SAT_LO) mag_sat = SAT_LO[DATA_WIDTH-1:0];
      else                      mag_sat = scaled[DATA_WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         x_r       <= '0;
         y_r       <= '0;
         z_r       <= '0;
         iter      <= '0;
         busy      <= 1'b0;
         gain_pend <= 1'b0;
         y_zero    <= 1'b0;
         x_neg     <= 1'b0;
         angle_out <= '0;
         mag_out   <= '0;
         valid     <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (enable) begin
            // Pre-rotation by pi keeps x >= 0 so the iterations converge
            // over the full atan2 range.
            if (x_in[DATA_WIDTH-1]) begin
               x_r <= -x_ext;
               y_r <= -y_ext;
               z_r <= Z_PI;
            end else begin
               x_r <= x_ext;
               y_r <= y_ext;
               z_r <= '0;
            end
            y_zero    <= (y_in == '0);
            x_neg     <= x_in[DATA_WIDTH-1];
            iter      <= '0;
            busy      <= 1'b1;
            gain_pend <= 1'b0;
         end else if (busy) begin
            x_r  <= x_nx;
            y_r  <= y_nx;
            z_r  <= z_nx;
            iter <= iter + 1'b1;
            if (iter == IW'(CORDIC_STAGES - 1)) begin
               busy      <= 1'b0;
               gain_pend <= 1'b1;
            end
         end else if (gain_pend) begin
            gain_pend <= 1'b0;
            valid     <= 1'b1;
            mag_out   <= mag_sat;
            // A zero y lies exactly on an axis; report the exact angle
            // instead of the micro-rotation residue around it.
            if (y_zero) angle_out <= x_neg ? Z_PI : '0;
            else        angle_out <= z_r;
         end
      end
   end
endmodule

module sequential_cordic_processor_top #(
   parameter int DATA_WIDTH    = 16,
   parameter int ANGLE_WIDTH   = 16,
   parameter int N_DIM         = 7,
   parameter int CORDIC_WIDTH  = 22,
   parameter int CORDIC_STAGES = 16
) (
   input  logic                               clk,
   input  logic                               nreset,
   input  logic                               start,
   input  logic [DATA_WIDTH*N_DIM-1:0]        w_in_flat,
   output logic [ANGLE_WIDTH*(N_DIM-1)-1:0]   theta_out,
   output logic                               done,
   output logic [2:0]                         fsm_state
);
   localparam int KW = (N_DIM > 2) ? $clog2(N_DIM) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(N_DIM - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_ISSUE = 3'd2,
      S_WAIT  = 3'd3,
      S_STORE = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t                          state;
   logic [DATA_WIDTH*N_DIM-1:0]     w_lat;
   logic signed [DATA_WIDTH-1:0]    x_reg, y_sel;
   logic [KW-1:0]                   k;
   logic                            core_en, core_valid;
   logic signed [ANGLE_WIDTH-1:0]   core_angle;
   logic signed [DATA_WIDTH-1:0]    core_mag;

   assign fsm_state = state;
   // y operand of step k is w(k+1), i.e. slice index k of the latched vector.
   assign y_sel = w_lat[k*DATA_WIDTH +: DATA_WIDTH];

   cordic_vectoring_top1 #(
      .DATA_WIDTH    (DATA_WIDTH),
      .ANGLE_WIDTH   (ANGLE_WIDTH),
      .CORDIC_WIDTH  (CORDIC_WIDTH),
      .CORDIC_STAGES (CORDIC_STAGES)
   ) u_core (
      .clk       (clk),
      .nreset    (nreset),
      .enable    (core_en),
      .x_in      (x_reg),
      .y_in      (y_sel),
      .angle_out (core_angle),
      .mag_out   (core_mag),
      .valid     (core_valid)
   );

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state     <= S_IDLE;
         w_lat     <= '0;
         x_reg     <= '0;
         k         <= '0;
         core_en   <= 1'b0;
         theta_out <= '0;
         done      <= 1'b0;
      end else begin
         core_en <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  w_lat <= w_in_flat;
                  k     <= KW'(1);
                  done  <= 1'b0;
                  state <= S_LOAD;
               end
            end
            S_LOAD: begin
               x_reg   <= w_lat[DATA_WIDTH-1:0];
               core_en <= 1'b1;   // high during ISSUE
               state   <= S_ISSUE;
            end
            S_ISSUE: state <= S_WAIT;
            S_WAIT: begin
               if (core_valid) state <= S_STORE;
            end
            S_STORE: begin
               theta_out[(int'(k) - 1)*ANGLE_WIDTH +: ANGLE_WIDTH] <= core_angle;
               x_reg <= core_mag;
               if (k == K_LAST) begin
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  k       <= k + 1'b1;
                  core_en <= 1'b1;
                  state   <= S_ISSUE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sequential_cordic_processor_top.sv
module tb_sequential_cordic_processor_top;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int N  = 7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  logic                 start7 = 1'b0;
  logic [DW*N-1:0]      w7 = '0;
  logic [AW*(N-1)-1:0]  theta7;
  logic                 done7;
  logic [2:0]           st7;

  logic                 start2 = 1'b0;
  logic [DW*2-1:0]      w2 = '0;
  logic [AW-1:0]        theta2;
  logic                 done2;
  logic [2:0]           st2;

  sequential_cordic_processor_top dut7 (
    .clk(clk), .nreset(nreset), .start(start7), .w_in_flat(w7),
    .theta_out(theta7), .done(done7), .fsm_state(st7));

  sequential_cordic_processor_top #(.N_DIM(2)) dut2 (
    .clk(clk), .nreset(nreset), .start(start2), .w_in_flat(w2),
    .theta_out(theta2), .done(done2), .fsm_state(st2));

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [AW-1:0] exp_q[$];

  task automatic check_angle(input string name, input logic [AW-1:0] act,
                             input int exp, input int tol);
    int d;
    n_cmp++;
    d = int'($signed(act)) - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d", name, $signed(act), exp, tol);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input logic [AW-1:0] act,
                             input int lo, input int hi);
    int v;
    n_cmp++;
    v = int'($signed(act));
    if (v < lo || v > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, expected within [%0d, %0d]", name, v, lo, hi);
    end
  endtask

  // Pops N-1 expected angles and compares them against theta7.
  task automatic score7(input string name, input int tol);
    logic [AW-1:0] e;
    for (int j = 0; j < N-1; j++) begin
      e = exp_q.pop_front();
      check_angle($sformatf("%s th%0d", name, j+1), theta7[j*AW +: AW], int'($signed(e)), tol);
    end
  endtask

  task automatic push_exp(input logic [AW*(N-1)-1:0] th);
    for (int j = 0; j < N-1; j++) exp_q.push_back(th[j*AW +: AW]);
  endtask

  // ---------------- drivers ----------------
  // Returns the number of rising edges from the start-sampling edge to done.
  // Optionally drives a second start (with w_busy) busy_at cycles in.
  task automatic run7(input logic [DW*N-1:0] w, input int busy_at,
                      input logic [DW*N-1:0] w_busy, output int lat);
    @(negedge clk);
    w7 = w;
    start7 = 1'b1;
    @(posedge clk);
    #1;
    start7 = 1'b0;
    check_int("done low after start", int'(done7), 0);
    lat = 0;
    while (done7 !== 1'b1 && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == busy_at) begin
        w7 = w_busy;
        start7 = 1'b1;
      end else begin
        start7 = 1'b0;
      end
    end
  endtask

  task automatic run2(input logic [DW*2-1:0] w, output int lat);
    @(negedge clk);
    w2 = w;
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    lat = 0;
    while (done2 !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  // ---------------- vector tables ----------------
  typedef struct {
    string               name;
    logic [DW*N-1:0]     w;     // {w7 .. w1}
    logic [AW*(N-1)-1:0] th;    // {th6 .. th1}
    int                  tol;
  } vec_t;

  typedef struct {
    string         name;
    logic [DW*2-1:0] w;         // {w2, w1}
    int            th;
    int            tol;
  } quad_t;

  vec_t  vecs[4];
  quad_t quads[5];

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;

    vecs[0] = '{"ref",
      {16'sd1000, 16'sd500, 16'sd500, 16'sd0, 16'sd2000, 16'sd1000, 16'sd1000},
      {16'sd3899, 16'sd2059, 16'sd2100, 16'sd0, 16'sd9964, 16'sd8192}, 8};
    vecs[1] = '{"zero", '0, '0, 0};
    vecs[2] = '{"neg_w1",
      {16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, -16'sd1000},
      {16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, -16'sd32768}, 0};
    vecs[3] = '{"axis",
      {16'sd0, 16'sd0, 16'sd0, 16'sd0, -16'sd1000, 16'sd1000, 16'sd0},
      {16'sd0, 16'sd0, 16'sd0, 16'sd0, -16'sd8192, 16'sd16384}, 8};

    quads[0] = '{"q +x",  {16'sd0,     16'sd1000},  0,      0};
    quads[1] = '{"q +y",  {16'sd1000,  16'sd0},     16384,  8};
    quads[2] = '{"q -x",  {16'sd0,    -16'sd1000}, -32768,  0};
    quads[3] = '{"q -x-y",{-16'sd1000,-16'sd1000}, -24576,  8};
    quads[4] = '{"q -y",  {-16'sd1000, 16'sd0},    -16384,  8};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_int("reset theta7", int'(theta7 != '0), 0);
    check_int("reset done7", int'(done7), 0);
    check_int("reset state7", int'(st7), 0);
    check_int("reset done2", int'(done2), 0);
    @(negedge clk);
    nreset = 1'b1;

    // table-driven vectors on the 7-element instance
    for (int i = 0; i < 4; i++) begin
      push_exp(vecs[i].th);
      run7(vecs[i].w, 0, '0, lat);
      check_int({vecs[i].name, " latency"}, lat, 121);
      score7(vecs[i].name, vecs[i].tol);
    end

    // done and results hold in DONE
    repeat (5) @(posedge clk);
    #1;
    check_int("done held", int'(done7), 1);
    check_int("state DONE", int'(st7), 5);
    push_exp(vecs[3].th);
    score7("axis held", vecs[3].tol);

    // saturation: running magnitude must clamp, not wrap
    run7({N{16'sd32767}}, 0, '0, lat);
    check_int("sat latency", lat, 121);
    check_angle("sat th1", theta7[AW-1:0], 8192, 8);
    for (int j = 1; j < N-1; j++)
      check_range($sformatf("sat th%0d", j+1), theta7[j*AW +: AW], 1, 8200);

    // start while busy is ignored; input changes after LOAD have no effect
    push_exp(vecs[3].th);
    run7(vecs[3].w, 50, vecs[0].w, lat);
    check_int("busy latency", lat, 121);
    score7("busy", vecs[3].tol);

    // start from DONE with the new vector
    push_exp(vecs[0].th);
    run7(vecs[0].w, 0, '0, lat);
    check_int("restart latency", lat, 121);
    score7("restart", vecs[0].tol);

    // quadrant sweep on the 2-element instance
    for (int i = 0; i < 5; i++) begin
      run2(quads[i].w, lat);
      check_int({quads[i].name, " latency"}, lat, 21);
      check_angle(quads[i].name, theta2, quads[i].th, quads[i].tol);
    end

    // reset in the middle of WAIT
    @(negedge clk);
    w7 = vecs[3].w;
    start7 = 1'b1;
    @(posedge clk);
    #1;
    start7 = 1'b0;
    repeat (30) @(posedge clk);
    #3;
    check_int("pre-reset state WAIT", int'(st7), 3);
    nreset = 1'b0;
    #1;
    check_int("async reset theta7", int'(theta7 != '0), 0);
    check_int("async reset done7", int'(done7), 0);
    check_int("async reset state7", int'(st7), 0);
    @(negedge clk);
    nreset = 1'b1;
    push_exp(vecs[0].th);
    run7(vecs[0].w, 0, '0, lat);
    check_int("post-reset latency", lat, 121);
    score7("post-reset", vecs[0].tol);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
